// File: rtl/obstacle_tracker_if.sv
// Spawner and draw-FSM bus for obstacle_tracker.
// The master drives spawn requests and read indices; the slave returns slot data.
interface obstacle_tracker_if #(
    parameter int NUM_SLOTS = 4
);
    localparam int IW = $clog2(NUM_SLOTS);

    logic          spawn;
    logic [9:0]    spawn_y;
    logic [IW-1:0] rd_idx;
    logic          rd_valid;
    logic [9:0]    rd_x;
    logic [9:0]    rd_y;

    modport master (
        output spawn, spawn_y, rd_idx,
        input  rd_valid, rd_x, rd_y
    );

    modport slave (
        input  spawn, spawn_y, rd_idx,
        output rd_valid, rd_x, rd_y
    );
endinterface

// File: rtl/obstacle_tracker.sv
// Obstacle slot table: allocates on spawn, moves left on tick, retires off-screen.
// Macro SPAWN_EDGE_EN: when defined, a held spawn allocates only on its rising edge.
module obstacle_tracker #(
    parameter int NUM_SLOTS = 4,
    parameter int X_START   = 639,
    parameter int Y_MAX     = 440,
    parameter int SPEED     = 4,
    localparam int CW       = $clog2(NUM_SLOTS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  tick,
    obstacle_tracker_if.slave     bus,
    output logic [CW-1:0]         count,
    output logic                  retire,
    output logic                  drop
);
    localparam logic [9:0] XS = 10'(X_START);
    localparam logic [9:0] YM = 10'(Y_MAX);
    localparam logic [9:0] SP = 10'(SPEED);

    logic [NUM_SLOTS-1:0] valid;
    logic [9:0]           x [NUM_SLOTS];
    logic [9:0]           y [NUM_SLOTS];

    logic [NUM_SLOTS-1:0] valid_n;
    logic [9:0]           x_n [NUM_SLOTS];
    logic [9:0]           y_n [NUM_SLOTS];
    logic [CW-1:0]        count_n;
    logic                 retire_n;
    logic                 drop_n;
    logic                 found;
    logic                 spawn_evt;
    logic                 accept;
    logic [9:0]           y_clamp;

`ifdef SPAWN_EDGE_EN
    logic spawn_q;

    // Spawn history: samples every cycle, even while disabled
    always_ff @(posedge clk) begin
        if (reset) spawn_q <= 1'b0;
        else       spawn_q <= bus.spawn;
    end

    assign spawn_evt = bus.spawn & ~spawn_q;
`else
    assign spawn_evt = bus.spawn;
`endif

    assign accept  = enable & spawn_evt;
    assign y_clamp = (bus.spawn_y > YM) ? YM : bus.spawn_y;

    // Next slot state: move/retire on tick, then allocate into a slot free at cycle start
    always_comb begin
        valid_n  = valid;
        x_n      = x;
        y_n      = y;
        retire_n = 1'b0;
        drop_n   = 1'b0;
        found    = 1'b0;
        count_n  = '0;
        if (enable && tick) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (valid[i]) begin
                    if (x[i] < SP) begin
                        valid_n[i] = 1'b0;
                        x_n[i]     = '0;
                        y_n[i]     = '0;
                        retire_n   = 1'b1;
                    end else begin
                        x_n[i] = x[i] - SP;
                    end
                end
            end
        end
        if (accept) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (!valid[i] && !found) begin
                    found      = 1'b1;
                    valid_n[i] = 1'b1;
                    x_n[i]     = XS;
                    y_n[i]     = y_clamp;
                end
            end
            if (!found) drop_n = 1'b1;
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            count_n = count_n + CW'(valid_n[i]);
        end
    end

    // Slot table, status pulses and registered read port
    always_ff @(posedge clk) begin
        if (reset) begin
            valid        <= '0;
            count        <= '0;
            retire       <= 1'b0;
            drop         <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_x     <= '0;
            bus.rd_y     <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x[i] <= '0;
                y[i] <= '0;
            end
        end else begin
            valid  <= valid_n;
            x      <= x_n;
            y      <= y_n;
            count  <= count_n;
            retire <= retire_n;
            drop   <= drop_n;
            if (int'(bus.rd_idx) < NUM_SLOTS) begin
                bus.rd_valid <= valid_n[bus.rd_idx];
                bus.rd_x     <= x_n[bus.rd_idx];
                bus.rd_y     <= y_n[bus.rd_idx];
            end else begin
                bus.rd_valid <= 1'b0;
                bus.rd_x     <= '0;
                bus.rd_y     <= '0;
            end
        end
    end
endmodule

// File: tb/tb_obstacle_tracker.sv
// Scoreboard bench for obstacle_tracker with a slot-list reference model.
// Directed scenarios followed by randomized traffic.
module tb_obstacle_tracker;
    localparam int NS = 4;
    localparam int XS = 639;
    localparam int YM = 440;
    localparam int SP = 4;
`ifdef SPAWN_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    typedef struct {
        bit v;
        int x;
        int y;
        int c;
        bit r;
        bit d;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       tick;
    logic [2:0] count;
    logic       retire;
    logic       drop;

    obstacle_tracker_if #(.NUM_SLOTS(NS)) bus ();

    obstacle_tracker #(
        .NUM_SLOTS(NS), .X_START(XS), .Y_MAX(YM), .SPEED(SP)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .tick(tick),
        .bus(bus), .count(count), .retire(retire), .drop(drop)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    exp_t sb [$];

    // model state: one entry per slot
    bit m_v [NS];
    int m_x [NS];
    int m_y [NS];
    bit m_spq;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input bit rst, input bit en, input bit sp,
                        input int sy, input bit tk, input int idx);
        exp_t e;
        int   free;
        bit   evt;
        @(negedge clk);
        reset       = rst;
        enable      = en;
        bus.spawn   = sp;
        bus.spawn_y = 10'(sy);
        tick        = tk;
        bus.rd_idx  = 2'(idx);
        e.r = 0;
        e.d = 0;
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                m_v[i] = 0; m_x[i] = 0; m_y[i] = 0;
            end
            m_spq = 0;
        end else begin
            evt  = sp && !(EDGE && m_spq);
            free = -1;
            for (int i = NS - 1; i >= 0; i--) if (!m_v[i]) free = i;
            if (en && tk) begin
                for (int i = 0; i < NS; i++) begin
                    if (m_v[i] && m_x[i] < SP) begin
                        m_v[i] = 0; m_x[i] = 0; m_y[i] = 0; e.r = 1;
                    end else if (m_v[i]) begin
                        m_x[i] = m_x[i] - SP;
                    end
                end
            end
            if (en && evt) begin
                if (free < 0) e.d = 1;
                else begin
                    m_v[free] = 1;
                    m_x[free] = XS;
                    m_y[free] = (sy > YM) ? YM : sy;
                end
            end
            m_spq = sp;
        end
        e.c = 0;
        for (int i = 0; i < NS; i++) e.c += int'(m_v[i]);
        e.v = m_v[idx % NS];
        e.x = m_x[idx % NS];
        e.y = m_y[idx % NS];
        sb.push_back(e);
    endtask

    task automatic look;
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge presents a new output set; compare with the oldest expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (bus.rd_valid !== e.v || int'(bus.rd_x) != e.x ||
                int'(bus.rd_y) != e.y || int'(count) != e.c ||
                retire !== e.r || drop !== e.d) begin
                errors++;
                $display("FAIL sb t=%0t got v=%0b x=%0d y=%0d c=%0d r=%0b d=%0b expected v=%0b x=%0d y=%0d c=%0d r=%0b d=%0b",
                         $time, bus.rd_valid, bus.rd_x, bus.rd_y, count, retire, drop,
                         e.v, e.x, e.y, e.c, e.r, e.d);
            end
        end
    end

    initial begin
        int hold;
        bit sp;
        reset = 1; enable = 0; tick = 0;
        bus.spawn = 0; bus.spawn_y = 0; bus.rd_idx = 0;
        m_spq = 0;
        for (int i = 0; i < NS; i++) begin
            m_v[i] = 0; m_x[i] = 0; m_y[i] = 0;
        end

        // reset and idle
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, i % NS);
        look();
        chk("idle_count", int'(count), 0);

        // held spawn, y=100
        hold = EDGE ? 5 : 1;
        for (int i = 0; i < hold; i++) step(0, 1, 1, 100, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        look();
        chk("spawn_count", int'(count), 1);
        chk("spawn_x", int'(bus.rd_x), XS);
        chk("spawn_y", int'(bus.rd_y), 100);

        // clamp and travel to the left edge
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 1000, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        look();
        chk("clamp_y", int'(bus.rd_y), YM);
        for (int i = 0; i < 159; i++) step(0, 1, 0, 0, 1, 0);
        look();
        chk("x_at_3", int'(bus.rd_x), 3);
        step(0, 1, 0, 0, 1, 0);
        look();
        chk("retire_pulse", int'(retire), 1);
        chk("retire_count", int'(count), 0);
        chk("retire_valid", int'(bus.rd_valid), 0);
        step(0, 1, 0, 0, 0, 0);
        look();
        chk("retire_drop", int'(retire), 0);

        // fill all slots, then overflow
        for (int i = 0; i < NS; i++) begin
            step(0, 1, 1, 50 * i, 0, i);
            step(0, 1, 0, 0, 0, i);
        end
        step(0, 1, 1, 7, 0, 3);
        look();
        chk("drop_pulse", int'(drop), 1);
        chk("drop_count", int'(count), NS);
        chk("drop_slot3_y", int'(bus.rd_y), 150);
        step(0, 1, 0, 0, 0, 0);
        look();
        chk("drop_clear", int'(drop), 0);

        // retire and spawn in the same cycle
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 20, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 159; i++) step(0, 1, 0, 0, 1, 0);
        step(0, 1, 1, 30, 1, 1);
        look();
        chk("same_retire", int'(retire), 1);
        chk("same_slot1_x", int'(bus.rd_x), XS);
        chk("same_count", int'(count), 1);
        step(0, 1, 0, 0, 0, 0);
        look();
        chk("same_slot0", int'(bus.rd_valid), 0);

        // freeze with enable low, then reset mid-run
        step(0, 1, 1, 60, 0, 0);
        step(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++)
            step(0, 0, 1'($urandom), $urandom_range(0, 1023), 1'($urandom), i % NS);
        step(1, 1, 1, 5, 1, 1);
        look();
        chk("midreset_count", int'(count), 0);
        chk("midreset_valid", int'(bus.rd_valid), 0);

        // random traffic
        sp = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) sp = ~sp;
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 9) != 0,
                 sp,
                 $urandom_range(0, 1023),
                 (i % 1000 < 500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) != 0),
                 $urandom_range(0, NS - 1));
        end

        step(0, 1, 0, 0, 0, 0);
        look();
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
